// File: rtl/axi_lite_sram_responder.sv
// AXI4-Lite slave backed by an internal word array, with independent read and
// write channels that each respond after a fixed, parameterised latency.
module axi_lite_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [2:0] W_IDLE   = 3'd0;
  localparam logic [2:0] W_GOT_AW = 3'd1;
  localparam logic [2:0] W_GOT_W  = 3'd2;
  localparam logic [2:0] W_WAIT   = 3'd3;
  localparam logic [2:0] W_RESP   = 3'd4;

  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // The offset test also covers windows that end exactly at the top of the
  // 32-bit address space, where BASE_ADDR + 4*DEPTH would overflow.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic idx_t word_index(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - BASE_ADDR;
    return idx_t'(offset >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  logic [1:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] ar_addr_q;

  logic [2:0]  w_state;
  logic [3:0]  w_count;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic wr_commit;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign awready = (w_state == W_IDLE) || (w_state == W_GOT_W);
  assign wready  = (w_state == W_IDLE) || (w_state == W_GOT_AW);
  assign bvalid  = (w_state == W_RESP);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign wr_commit = (w_state == W_WAIT) && (w_count == 4'd0) && addr_in_range(aw_addr_q);

  // R_WAIT always lasts at least one cycle, so the array sample (and rvalid)
  // lands exactly RD_LATENCY edges after the AR handshake, including latency 1.
  // NOTE: state registers use non-blocking assignments so every register in
  // the block updates from the same pre-edge values, like real flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= R_IDLE;
      r_count   <= 4'd0;
      ar_addr_q <= 32'd0;
      rdata     <= 32'd0;
      rresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr_q <= araddr;
            r_count   <= RD_LOAD;
            r_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= R_RESP;
            if (addr_in_range(ar_addr_q)) begin
              rdata <= mem[word_index(ar_addr_q)];
              rresp <= RESP_OKAY;
            end else begin
              rdata <= 32'd0;
              rresp <= RESP_SLVERR;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      w_count   <= 4'd0;
      aw_addr_q <= 32'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      bresp     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_count <= WR_LOAD;
            w_state <= W_WAIT;
          end else if (aw_hs) begin
            w_state <= W_GOT_AW;
          end else if (w_hs) begin
            w_state <= W_GOT_W;
          end
        end
        W_GOT_AW: begin
          if (w_hs) begin
            w_count <= WR_LOAD;
            w_state <= W_WAIT;
          end
        end
        W_GOT_W: begin
          if (aw_hs) begin
            w_count <= WR_LOAD;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_count == 4'd0) begin
            w_state <= W_RESP;
            bresp   <= addr_in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            w_count <= w_count - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it can map onto a RAM macro; commits are
  // gated by the write FSM state, which is reset, so a dropped write never lands.
  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) begin
          mem[word_index(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// every cycle against a cycle-counting transaction model of the responder.
module tb_axi_lite_sram_responder;

  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          RDL  = 2;
  localparam int          WRL  = 1;

  logic        clock, reset;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  axi_lite_sram_responder #(
    .DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * (longint'(1) << DL));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  logic [31:0] mem_m [int];
  bit          m_rd_busy, m_rvalid, m_aw_have, m_w_have, m_wr_pend, m_bvalid;
  logic [31:0] m_rdata, m_raddr, m_waddr, m_wdata, m_word;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;
  longint      m_rd_due, m_wr_due, edge_n, nxt;
  bit          p_ar, p_r, p_aw, p_w, p_b;

  initial edge_n = 0;

  always @(negedge clock) begin
    if (!reset) begin
      m_rd_busy = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
      m_aw_have = 0; m_w_have = 0; m_wr_pend = 0; m_bvalid = 0; m_bresp = 2'b00;
      check("rst_arready", arready, 1); check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);   check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);   check("rst_rdata", rdata, 0);
      check("rst_rresp", rresp, 0);     check("rst_bresp", bresp, 0);
    end else begin
      check("mon_arready", arready, !m_rd_busy);
      check("mon_rvalid", rvalid, m_rvalid);
      if (m_rvalid) begin
        check("mon_rdata", rdata, m_rdata);
        check("mon_rresp", rresp, m_rresp);
      end
      check("mon_awready", awready, !m_aw_have);
      check("mon_wready", wready, !m_w_have);
      check("mon_bvalid", bvalid, m_bvalid);
      if (m_bvalid) check("mon_bresp", bresp, m_bresp);

      // what happens at the coming rising edge
      nxt  = edge_n + 1;
      p_ar = arvalid && !m_rd_busy;
      p_r  = m_rvalid && rready;
      p_aw = awvalid && !m_aw_have;
      p_w  = wvalid && !m_w_have;
      p_b  = m_bvalid && bready;

      if (p_r) begin m_rd_busy = 0; m_rvalid = 0; end
      if (p_ar) begin m_rd_busy = 1; m_raddr = araddr; m_rd_due = nxt + RDL; end
      // read sample uses the array before any commit on the same edge
      if (m_rd_busy && !m_rvalid && m_rd_due == nxt) begin
        m_rvalid = 1;
        if (in_rng(m_raddr)) begin
          m_rdata = mem_m.exists(widx(m_raddr)) ? mem_m[widx(m_raddr)] : 'x;
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
      end

      if (m_wr_pend && m_wr_due == nxt) begin
        m_wr_pend = 0;
        m_bvalid  = 1;
        if (in_rng(m_waddr)) begin
          m_word = mem_m.exists(widx(m_waddr)) ? mem_m[widx(m_waddr)] : 'x;
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_word[8*b +: 8] = m_wdata[8*b +: 8];
          mem_m[widx(m_waddr)] = m_word;
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
      end
      if (p_b) begin m_bvalid = 0; m_aw_have = 0; m_w_have = 0; end
      if (p_aw) begin m_aw_have = 1; m_waddr = awaddr; end
      if (p_w) begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if ((p_aw || p_w) && m_aw_have && m_w_have) begin
        m_wr_pend = 1;
        m_wr_due  = nxt + WRL;
      end
    end
    edge_n = edge_n + 1;
  end

  // ---------------- drivers ----------------
  task automatic sync();
    @(posedge clock); #1;
  endtask

  // Edges counted from call; lat = edges from last AW/W handshake to bvalid.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    int cyc, done_edge, rise;
    bit aw_done, w_done, hs_aw, hs_w, hs_b, got;
    cyc = 0; done_edge = -1; rise = -1; aw_done = 0; w_done = 0; got = 0;
    resp = 'x; lat = -1; bready = 1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1; awaddr = a; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1; wdata = d; wstrb = s; end
      @(negedge clock);
      if (aw_done && !w_done) begin
        check("got_aw_awready", awready, 0); check("got_aw_wready", wready, 1);
      end
      if (w_done && !aw_done) begin
        check("got_w_wready", wready, 0); check("got_w_awready", awready, 1);
      end
      if (bvalid && rise < 0) begin rise = cyc; resp = bresp; end
      hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
      sync(); cyc++;
      if (hs_aw) begin awvalid = 0; aw_done = 1; end
      if (hs_w) begin wvalid = 0; w_done = 1; end
      if ((hs_aw || hs_w) && aw_done && w_done) done_edge = cyc;
      if (hs_b) got = 1;
    end
    bready = 0;
    if (!got) begin
      check("write_timeout", 0, 1);
      awvalid = 0; wvalid = 0;
    end else begin
      lat = rise - done_edge;
    end
  endtask

  // hold>0 keeps rready low for that many cycles once rvalid is seen.
  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    int cyc, hs_edge, rise, held;
    bit hs_ar, hs_r, got;
    cyc = 0; hs_edge = -1; rise = -1; held = 0; got = 0;
    d = 'x; resp = 'x; lat = -1;
    arvalid = 1; araddr = a; rready = (hold == 0);
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (rvalid && rise < 0) begin rise = cyc; d = rdata; resp = rresp; end
      if (rise >= 0 && held < hold) begin
        check("bp_rvalid", rvalid, 1); check("bp_rdata", rdata, d);
        check("bp_arready", arready, 0);
        held++;
      end
      hs_ar = arvalid && arready; hs_r = rvalid && rready;
      sync(); cyc++;
      if (hs_ar) begin arvalid = 0; hs_edge = cyc; end
      if (rise >= 0 && held >= hold) rready = 1;
      if (hs_r) got = 1;
    end
    rready = 0;
    if (!got) begin
      check("read_timeout", 0, 1);
      arvalid = 0;
    end else begin
      lat = rise - hs_edge;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h7FFF_FFFC;
      1:       return BASE + 32'h4000 + 32'($urandom_range(0, 3)) * 4;
      2:       return BASE + 32'h3FFC;
      default: return BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [1:0]  resp;
  int          lat;
  bit          s_ar, s_aw, s_w;
  bit          seen;

  initial begin
    reset = 0;
    araddr = '0; arvalid = 0; rready = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    check("init_arready", arready, 1); check("init_awready", awready, 1);
    check("init_wready", wready, 1);   check("init_rvalid", rvalid, 0);
    check("init_bvalid", bvalid, 0);
    sync();

    // basic write then read
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat);
    check("t1_bresp", resp, 2'b00); check("t1_blat", lat, 1);
    axi_read(32'h8000_0010, 0, d, resp, lat);
    check("t1_rdata", d, 32'hDEAD_BEEF); check("t1_rresp", resp, 2'b00);
    check("t1_rlat", lat, 2);

    // byte strobes
    axi_write(32'h8000_0014, 32'h1122_3344, 4'hF, 0, 0, resp, lat);
    axi_write(32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 0, 0, resp, lat);
    axi_read(32'h8000_0014, 0, d, resp, lat);
    check("strb_rdata", d, 32'h11BB_33DD);

    // AW three cycles ahead of W, then W ahead of AW
    axi_write(32'h8000_0018, 32'h0A0B_0C0D, 4'hF, 0, 3, resp, lat);
    check("aw_first_blat", lat, 1); check("aw_first_bresp", resp, 2'b00);
    axi_write(32'h8000_001C, 32'h5566_7788, 4'hF, 3, 0, resp, lat);
    check("w_first_blat", lat, 1); check("w_first_bresp", resp, 2'b00);
    axi_read(32'h8000_0018, 0, d, resp, lat);
    check("aw_first_rdata", d, 32'h0A0B_0C0D);
    axi_read(32'h8000_001C, 0, d, resp, lat);
    check("w_first_rdata", d, 32'h5566_7788);

    // out of range: reads error, writes leave wrapped indices untouched
    axi_write(32'h8000_0000, 32'hC0FF_EE00, 4'hF, 0, 0, resp, lat);
    axi_write(32'h8000_3FFC, 32'h5A5A_5A5A, 4'hF, 0, 0, resp, lat);
    axi_read(32'h7FFF_FFFC, 0, d, resp, lat);
    check("oor_lo_rdata", d, 32'h0); check("oor_lo_rresp", resp, 2'b10);
    axi_read(32'h8000_4000, 0, d, resp, lat);
    check("oor_hi_rdata", d, 32'h0); check("oor_hi_rresp", resp, 2'b10);
    axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    check("oor_hi_bresp", resp, 2'b10);
    axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    check("oor_lo_bresp", resp, 2'b10);
    axi_read(32'h8000_0000, 0, d, resp, lat);
    check("oor_wrap0", d, 32'hC0FF_EE00);
    axi_read(32'h8000_3FFC, 0, d, resp, lat);
    check("oor_wrap_top", d, 32'h5A5A_5A5A);

    // zero strobe is an OKAY no-op
    axi_write(32'h8000_0010, 32'h0, 4'h0, 0, 0, resp, lat);
    check("strb0_bresp", resp, 2'b00);

    // read backpressure, then immediate next AR
    axi_read(32'h8000_0010, 5, d, resp, lat);
    check("bp_data", d, 32'hDEAD_BEEF);
    @(negedge clock);
    check("bp_next_arready", arready, 1);
    sync();
    axi_read(32'h8000_0014, 0, d, resp, lat);
    check("bp_next_rdata", d, 32'h11BB_33DD);

    // reset during R_WAIT and W_GOT_AW
    axi_write(32'h8000_0020, 32'h1357_9BDF, 4'hF, 0, 0, resp, lat);
    arvalid = 1; araddr = 32'h8000_0010;
    awvalid = 1; awaddr = 32'h8000_0020; wdata = 32'h0; wstrb = 4'hF;
    @(negedge clock);
    sync();
    arvalid = 0; awvalid = 0;
    @(negedge clock);
    check("mid_arready", arready, 0); check("mid_awready", awready, 0);
    check("mid_wready", wready, 1);
    #2 reset = 0;
    #1;
    check("mid_rst_rvalid", rvalid, 0); check("mid_rst_bvalid", bvalid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    check("rel_arready", arready, 1); check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    sync();
    axi_read(32'h8000_0020, 0, d, resp, lat);
    check("mid_rst_word", d, 32'h1357_9BDF);

    // reset while both responses are waiting on ready
    arvalid = 1; araddr = 32'h8000_0010;
    awvalid = 1; awaddr = 32'h8000_0024; wvalid = 1; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    @(negedge clock);
    sync();
    arvalid = 0; awvalid = 0; wvalid = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      seen = rvalid && bvalid;
    end
    check("resp_wait_rvalid", rvalid, 1); check("resp_wait_bvalid", bvalid, 1);
    #2 reset = 0;
    #1;
    check("resp_rst_rvalid", rvalid, 0); check("resp_rst_bvalid", bvalid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    sync();

    // randomized concurrent traffic over a small window
    for (int i = 0; i < 16; i++)
      axi_write(BASE + 32'(i) * 4, $urandom, 4'hF, 0, 0, resp, lat);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      s_ar = arvalid && arready; s_aw = awvalid && awready; s_w = wvalid && wready;
      sync();
      if (s_ar) arvalid = 0;
      if (s_aw) awvalid = 0;
      if (s_w)  wvalid = 0;
      if (!arvalid && $urandom_range(0, 2) == 0) begin arvalid = 1; araddr = rand_addr(); end
      if (!awvalid && $urandom_range(0, 2) == 0) begin awvalid = 1; awaddr = rand_addr(); end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
      end
      rready = ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
    end
    rready = 1; bready = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      s_ar = arvalid && arready; s_aw = awvalid && awready; s_w = wvalid && wready;
      sync();
      if (s_ar) arvalid = 0;
      if (s_aw) awvalid = 0;
      if (s_w)  wvalid = 0;
    end
    check("drain_arvalid", arvalid, 0);
    check("drain_awvalid", awvalid, 0);
    check("drain_wvalid", wvalid, 0);
    @(negedge clock);
    check("drain_rvalid", rvalid, 0); check("drain_bvalid", bvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
